// File: rtl/m_dm_responder_if.sv
// Request/response bundle between the M-stage requester and the data-memory responder.
interface m_dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/m_dm_responder.sv
// Data-memory responder: byte-enable stores, whole-word loads with fixed latency, one request in flight.
// Optional store trace printing is enabled by defining DM_WRITE_TRACE_EN.
module m_dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    m_dm_responder_if.slave bus
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          in_range;
    logic [31:0]   word_addr;
    logic [AW-1:0] widx;
    logic          unused_ok;

    assign accept    = bus.req_valid && bus.req_ready;
    assign word_addr = {2'b00, bus.req_addr[31:2]};
    assign in_range  = word_addr < DEPTH_WORDS;
    assign widx      = bus.req_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_we || RD_LAT <= 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = 2'(RD_LAT - 2);
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - 2'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by reset_n so it reads low for the whole time reset is held.
    always_comb begin
        bus.req_ready = reset_n && (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    // Load data is captured at acceptance; stores and out-of-range requests return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= !in_range;
            rdata_q <= (!bus.req_we && in_range) ? mem[widx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.req_be[i]) mem[widx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

`ifdef DM_WRITE_TRACE_EN
    logic [31:0] merged;

    always_comb begin
        merged = mem[widx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.req_be[i]) merged[8*i +: 8] = bus.req_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && in_range && (|bus.req_be)) begin
            $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, merged);
        end
    end

    assign unused_ok = &{1'b0, bus.req_addr[1:0]};
`else
    assign unused_ok = &{1'b0, bus.req_addr[1:0], bus.req_pc};
`endif

endmodule
